// File: rtl/fft_frame_loader.sv
// ADC frame capture, DC removal/scaling, and burst feed into the FFT.
// One frame is buffered in a dual-port RAM, then streamed out on consecutive clocks.
module fft_frame_loader #(
  parameter int FFT_SIZE   = 2048,
  parameter int ADC_W      = 12,
  parameter int MIDSCALE   = 2048,
  parameter int GAIN_SHIFT = 3,
  localparam int ADDR_W    = $clog2(FFT_SIZE)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             arm,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             fft_ce,
  output logic [31:0]      fft_sample,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       overrun_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_STREAM,
    S_FLUSH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FFT_SIZE - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_full;
  logic [15:0]       r_cond;
  logic [ADDR_W-1:0] r_cond_addr;
  logic              r_cond_vld;
  logic              r_cond_last;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [15:0]       r_rd_data;
  logic              r_ce;
  logic              r_done;
  logic [7:0]        r_ovr;
  logic [15:0]       r_mem [FFT_SIZE];

  logic signed [31:0] w_d;
  logic signed [31:0] w_s;
  logic [15:0]        w_sat;
  logic               w_accept;
  logic               w_commit_last;
  logic               w_rd_en;
  logic               w_done_nxt;
  logic               w_ovr_inc;

  always_comb begin
    w_d = $signed(32'(adc_data)) - MIDSCALE;
    w_s = w_d <<< GAIN_SHIFT;
    if (w_s > 32'sd32767)
      w_sat = 16'h7fff;
    else if (w_s < -32'sd32768)
      w_sat = 16'h8000;
    else
      w_sat = w_s[15:0];
  end

  // r_full blocks strobes that arrive while the last write is still in flight
  assign w_accept      = (r_state == S_CAPTURE) && adc_valid && !r_full;
  assign w_commit_last = r_cond_vld && r_cond_last;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_wr_addr   <= '0;
      r_full      <= 1'b0;
      r_cond      <= '0;
      r_cond_addr <= '0;
      r_cond_vld  <= 1'b0;
      r_cond_last <= 1'b0;
      r_rd_addr   <= '0;
      r_ce        <= 1'b0;
      r_done      <= 1'b0;
      r_ovr       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cond_vld <= w_accept;
      r_ce       <= w_rd_en;
      r_done     <= w_done_nxt;
      if ((r_state == S_IDLE) && arm) begin
        r_wr_addr <= '0;
        r_full    <= 1'b0;
      end
      if (w_accept) begin
        r_cond      <= w_sat;
        r_cond_addr <= r_wr_addr;
        r_cond_last <= (r_wr_addr == LAST);
        r_wr_addr   <= r_wr_addr + 1'b1;
        if (r_wr_addr == LAST)
          r_full <= 1'b1;
      end
      if (w_commit_last)
        r_rd_addr <= '0;
      else if (w_rd_en)
        r_rd_addr <= r_rd_addr + 1'b1;
      if (w_ovr_inc)
        r_ovr <= r_ovr + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (arm) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_commit_last) w_state_nxt = S_STREAM;
      S_STREAM:  if (r_rd_addr == LAST) w_state_nxt = S_FLUSH;
      S_FLUSH:   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en    = (r_state == S_STREAM);
    w_done_nxt = (r_state == S_FLUSH);
    w_ovr_inc  = adc_valid && (r_ovr != 8'hff) &&
                 ((r_state == S_STREAM) || (r_state == S_FLUSH));
    busy       = (r_state != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (r_cond_vld)
      r_mem[r_cond_addr] <= r_cond;
    if (w_rd_en)
      r_rd_data <= r_mem[r_rd_addr];
  end

  assign fft_ce        = r_ce;
  assign fft_sample    = r_ce ? {r_rd_data, 16'h0000} : 32'h0;
  assign frame_done    = r_done;
  assign overrun_count = r_ovr;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: frame data, latency, overrun, resets, arm handling.
module tb_fft_frame_loader;

  localparam int N   = 16;
  localparam int AW  = 14;
  localparam int MID = 8192;
  localparam int GS  = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          arm = 1'b0;
  logic          adc_valid = 1'b0;
  logic [AW-1:0] adc_data = '0;
  logic          fft_ce;
  logic [31:0]   fft_sample;
  logic          busy;
  logic          frame_done;
  logic [7:0]    overrun_count;

  fft_frame_loader #(
    .FFT_SIZE  (N),
    .ADC_W     (AW),
    .MIDSCALE  (MID),
    .GAIN_SHIFT(GS)
  ) u_dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .arm          (arm),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .fft_ce       (fft_ce),
    .fft_sample   (fft_sample),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun_count(overrun_count)
  );

  always #5 clk_in = ~clk_in;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_e;
  int          run = 0;
  int          done_cnt = 0;
  int          exp_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] model(input logic [AW-1:0] d);
    int v;
    v = (int'(d) - MID) * (1 << GS);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [AW-1:0] gen(input int mode, input int k);
    if (mode == 0) return AW'(MID + k);
    if (mode == 1) begin
      if (k == 0) return '1;
      if (k == 1) return '0;
      if (k == 2) return AW'(MID - 1);
      if (k == 3) return AW'(MID);
    end
    return AW'($urandom_range(0, (1 << AW) - 1));
  endfunction

  always @(negedge clk_in) begin
    if (fft_ce) begin
      run++;
      if (sb.size() == 0) begin
        chk("ce_unexpected", 32'(fft_ce), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sample", fft_sample, {mon_e, 16'h0000});
      end
    end else begin
      chk("idle_zero", fft_sample, 32'h0);
      if (frame_done) begin
        chk("burst_len", 32'(run), 32'(N));
        done_cnt++;
      end
      run = 0;
    end
  end

  task automatic idle_chk(input string tag);
    chk({tag, "_ce"}, 32'(fft_ce), 32'd0);
    chk({tag, "_smp"}, fft_sample, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun_count), 32'(exp_ovr));
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_frame(input int mode, input bit ovr, input bit rearm,
                           input bit arm_strobe, input int rst_beat);
    int lat;
    int w;
    arm = 1'b1;
    if (arm_strobe) begin
      adc_valid = 1'b1;
      adc_data  = AW'($urandom);
    end
    step();
    arm = 1'b0;
    adc_valid = 1'b0;
    chk("busy_cap", 32'(busy), 32'd1);
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, 2)) step();
      adc_valid = 1'b1;
      adc_data  = gen(mode, k);
      sb.push_back(model(adc_data));
      if (rearm && k == 4) arm = 1'b1;
      if (k < N - 1) begin
        step();
        adc_valid = 1'b0;
        arm = 1'b0;
      end
    end
    lat = 0;
    do begin
      step();
      adc_valid = 1'b0;
      lat++;
    end while (!fft_ce && lat < 10);
    chk("latency", 32'(lat), 32'd3);
    chk("busy_stream", 32'(busy), 32'd1);
    if (rst_beat > 0) begin
      repeat (rst_beat - 1) step();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      sb.delete();
      exp_ovr = 0;
      idle_chk("rst_stream");
      return;
    end
    if (rearm) begin
      arm = 1'b1;
      step();
      arm = 1'b0;
    end
    if (ovr) begin
      for (int i = 0; i < N; i++) begin
        adc_valid = 1'b1;
        adc_data  = AW'($urandom);
        step();
        adc_valid = 1'b0;
      end
      exp_ovr = (exp_ovr + N > 255) ? 255 : exp_ovr + N;
    end
    w = 0;
    while (!frame_done && w < 50) begin
      step();
      w++;
    end
    chk("done_seen", 32'(frame_done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("ovr", 32'(overrun_count), 32'(exp_ovr));
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst_in = 1'b1;
    repeat (3) step();
    rst_in = 1'b0;
    idle_chk("reset");

    repeat (5) begin
      adc_valid = 1'b1;
      adc_data  = AW'($urandom);
      step();
      adc_valid = 1'b0;
      step();
    end
    idle_chk("idle_strobe");

    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 0, 0, 1, 0);
    run_frame(2, 1, 0, 0, 0);
    chk("ovr_first", 32'(overrun_count), 32'd16);
    for (int f = 0; f < 18; f++) run_frame(2, 1, 0, 0, 0);
    chk("ovr_sat", 32'(overrun_count), 32'd255);
    run_frame(1, 0, 0, 0, 0);

    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < 7; k++) begin
      adc_valid = 1'b1;
      adc_data  = AW'($urandom);
      step();
      adc_valid = 1'b0;
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    exp_ovr = 0;
    idle_chk("rst_cap");
    for (int i = 0; i < 30; i++) begin
      adc_valid = (i % 3 == 0);
      adc_data  = AW'($urandom);
      step();
    end
    adc_valid = 1'b0;
    idle_chk("rst_cap_quiet");

    run_frame(0, 0, 0, 0, 5);
    repeat (30) step();
    idle_chk("rst_str_quiet");

    d0 = done_cnt;
    run_frame(2, 0, 1, 0, 0);
    repeat (40) step();
    chk("single_frame", 32'(done_cnt), 32'(d0 + 1));
    idle_chk("rearm_quiet");

    d0 = done_cnt;
    run_frame(0, 0, 0, 0, 0);
    run_frame(2, 0, 0, 0, 0);
    chk("b2b_frames", 32'(done_cnt), 32'(d0 + 2));

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
